uartb_rx_burst: RTL

- Receive-side companion to the burst-capable UART transmit core. It sits directly downstream of the core's txd line, or in loopback on the same rxd pin.
- Deserialises 8N1 frames (LSB first) using 16x oversampling.
- Mode 0 (normal): every byte is presented to the CPU.
- Mode 1 (burst): four consecutive bytes are assembled into one 32-bit word, first byte received in q[7:0].
- Configured by the same wrbaud/d write that configures the transmitter.

---
 rtl/uartb_pkg.sv | 18 +
 rtl/uartb_rx_tick.sv | 47 ++++
 rtl/uartb_rx_burst.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/uartb_pkg.sv
// Shared definitions for the burst UART receive path. The transmit core
// decodes the same configuration word, so the field positions live here.
package uartb_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } rx_state_t;

  localparam int MODE_BIT        = 31;  // d[31]: 0 = byte mode, 1 = 32-bit burst
  localparam int DIV_W           = 9;   // prescaler divider width
  localparam int DIV_LSB         = 0;   // divider field position in d
  localparam int BYTES_PER_BURST = 4;

endpackage

// File: rtl/uartb_rx_tick.sv
// Oversample timebase for the receiver.
//   div     : prescaler terminal count; one tick every div+1 clocks
//   restart : zero both counters so mid_bit lands OVS/2 ticks later
//   tick    : one-clock oversample strobe
//   mid_bit : tick that falls in the middle of a bit cell
//   bit_end : tick that closes a bit cell (used as the idle bit-time clock)
module uartb_rx_tick
  import uartb_pkg::*;
#(
  parameter int OVS = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [DIV_W-1:0] div,
  input  logic             restart,
  output logic             tick,
  output logic             mid_bit,
  output logic             bit_end
);

  localparam int OW = $clog2(OVS);

  logic [DIV_W-1:0] pcnt;
  logic [OW-1:0]    ocnt;

  assign tick    = (pcnt == div);
  // ocnt holds the number of ticks already seen in this cell, so the
  // OVS/2-th tick is the one where ocnt reads OVS/2-1.
  assign mid_bit = tick && (ocnt == OW'(OVS/2 - 1));
  assign bit_end = tick && (ocnt == OW'(OVS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcnt <= '0;
      ocnt <= '0;
    end else if (restart) begin
      pcnt <= '0;
      ocnt <= '0;
    end else if (tick) begin
      pcnt <= '0;
      ocnt <= ocnt + 1'b1;  // OVS is a power of two, wraps cleanly
    end else begin
      pcnt <= pcnt + 1'b1;
    end
  end

endmodule

// File: rtl/uartb_rx_burst.sv
// 8N1 receiver with 16x oversampling and optional 4-byte burst assembly.
//   clk, rst_n : system clock, async active-low reset
//   rxd        : serial input (idle high, asynchronous)
//   d, wrbaud  : config write; d[31] mode, d[8:0] divider
//   rd         : CPU read strobe, clears dv/ferr/ovf
//   q          : {24'h0, byte} in mode 0, {b3,b2,b1,b0} in mode 1
//   dv/ferr/ovf: sticky data-valid / framing-or-timeout / overrun flags
//   busy       : frame in flight or partial burst held
module uartb_rx_burst
  import uartb_pkg::*;
#(
  parameter logic [DIV_W-1:0] DIV_RST      = 9'd7,
  parameter int               OVS          = 16,
  parameter int               TIMEOUT_BITS = 20
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rxd,
  input  logic [31:0] d,
  input  logic        wrbaud,
  input  logic        rd,
  output logic [31:0] q,
  output logic        dv,
  output logic        ferr,
  output logic        ovf,
  output logic        busy
);

  localparam int CNT_W = $clog2(BYTES_PER_BURST);
  localparam int TO_W  = $clog2(TIMEOUT_BITS + 1);

  rx_state_t state, nstate;

  logic             rx_s1, rx_s2, rx_s2_d, fall;
  logic             mode;
  logic [DIV_W-1:0] div, div_run;
  logic             tick, mid_bit, bit_end;
  logic             restart, accept, frame_err, tout, complete;
  logic [2:0]       bitcnt;
  logic [7:0]       shreg;
  logic             wh_ok;
  logic [CNT_W-1:0] cnt;
  logic [TO_W-1:0]  tcnt;
  logic [BYTES_PER_BURST-1:0][7:0] asm_q, word_b;
  logic [31:0]      word;
  logic             unused_d;

  assign unused_d = ^d[MODE_BIT-1:DIV_LSB+DIV_W];

  // Two-flop synchroniser plus one history flop for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) {rx_s1, rx_s2, rx_s2_d} <= 3'b111;
    else        {rx_s1, rx_s2, rx_s2_d} <= {rxd, rx_s1, rx_s2};
  end
  assign fall = rx_s2_d & ~rx_s2;

  // div_run is captured at the start edge so a frame in flight keeps the
  // divider it started with even if wrbaud lands mid-frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode    <= 1'b0;
      div     <= DIV_RST;
      div_run <= DIV_RST;
    end else begin
      if (wrbaud) begin
        mode <= d[MODE_BIT];
        div  <= d[DIV_LSB +: DIV_W];
      end
      if (restart) div_run <= div;
    end
  end

  uartb_rx_tick #(.OVS(OVS)) u_tick (
    .clk     (clk),
    .rst_n   (rst_n),
    .div     (div_run),
    .restart (restart),
    .tick    (tick),
    .mid_bit (mid_bit),
    .bit_end (bit_end)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nstate;
  end

  always_comb begin
    nstate    = state;
    restart   = 1'b0;
    accept    = 1'b0;
    frame_err = 1'b0;
    unique case (state)
      IDLE:      if (fall) begin nstate = START; restart = 1'b1; end
      START:     if (mid_bit) nstate = rx_s2 ? IDLE : DATA;
      DATA:      if (mid_bit && bitcnt == 3'd7) nstate = STOP;
      STOP:
        if (mid_bit) begin
          if (rx_s2) begin accept = 1'b1; nstate = IDLE; end
          else begin frame_err = 1'b1; nstate = WAIT_HIGH; end
        end
      // Leave only after the line has been high across a whole tick, so a
      // break never looks like a new start edge.
      WAIT_HIGH: if (tick && rx_s2 && wh_ok) nstate = IDLE;
      default:   nstate = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bitcnt <= '0;
      shreg  <= '0;
      wh_ok  <= 1'b0;
    end else begin
      if (restart) bitcnt <= '0;
      else if (state == DATA && mid_bit) begin
        bitcnt <= bitcnt + 1'b1;
        shreg  <= {rx_s2, shreg[7:1]};  // LSB arrives first
      end
      if (state != WAIT_HIGH || !rx_s2) wh_ok <= 1'b0;
      else if (tick)                    wh_ok <= 1'b1;
    end
  end

  // Burst assembly: the incoming byte is spliced into lane cnt so the
  // completed word is available in the same clock as the last stop bit.
  for (genvar i = 0; i < BYTES_PER_BURST; i++) begin : g_lane
    assign word_b[i] = (cnt == CNT_W'(i)) ? shreg : asm_q[i];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) asm_q <= '0;
    else if (accept && mode) begin
      for (int i = 0; i < BYTES_PER_BURST; i++)
        if (cnt == CNT_W'(i)) asm_q[i] <= shreg;
    end
  end

  assign word     = mode ? word_b : {24'h0, shreg};
  assign complete = accept && (!mode || cnt == CNT_W'(BYTES_PER_BURST - 1));
  assign tout     = mode && (cnt != '0) && (state == IDLE) && !fall &&
                    bit_end && (tcnt == TO_W'(TIMEOUT_BITS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      tcnt <= '0;
    end else begin
      if (wrbaud || frame_err || tout) cnt <= '0;
      else if (accept && mode)         cnt <= cnt + 1'b1;  // wraps after lane 3

      if (restart || cnt == '0 || !mode || wrbaud) tcnt <= '0;
      else if (state == IDLE && bit_end)           tcnt <= tcnt + 1'b1;
    end
  end

  // rd clears first; a result or error in the same clock overrides it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q    <= '0;
      dv   <= 1'b0;
      ferr <= 1'b0;
      ovf  <= 1'b0;
    end else begin
      if (rd) begin
        dv   <= 1'b0;
        ferr <= 1'b0;
        ovf  <= 1'b0;
      end
      if (complete) begin
        if (dv && !rd) ovf <= 1'b1;
        else begin
          q  <= word;
          dv <= 1'b1;
        end
      end
      if (frame_err || tout) ferr <= 1'b1;
    end
  end

  assign busy = (state != IDLE) || (cnt != '0);

endmodule
